// File: rtl/sni_axi_master.sv
// Slave-side NoC interface: replays one request packet as an AXI3 burst and returns the response packet; W and R beats pass through combinationally.
// Optional SNI_RRESP_TRAILER_EN: read data goes out as BODY flits, followed by a TAIL that carries the worst RRESP.
module sni_axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int XY_WIDTH   = 4,
  parameter int FLIT_WIDTH = DATA_WIDTH + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XY_WIDTH-1:0]   myx,
  input  logic [XY_WIDTH-1:0]   myy,
  input  logic [FLIT_WIDTH-1:0] rx_flit,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [FLIT_WIDTH-1:0] tx_flit,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [3:0]            M_AWID,
  output logic [ADDR_WIDTH-1:0] M_AWADDR,
  output logic [3:0]            M_AWLEN,
  output logic [2:0]            M_AWSIZE,
  output logic [1:0]            M_AWBURST,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [3:0]            M_WID,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  output logic [3:0]            M_WSTRB,
  output logic                  M_WLAST,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [3:0]            M_BID,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [3:0]            M_ARID,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [3:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [3:0]            M_RID,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int PAD = DATA_WIDTH - 9 - 4*XY_WIDTH;
  localparam logic [1:0] T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AW, S_W, S_B, S_WH, S_WT, S_AR, S_RH, S_R, S_RT
  } state_t;

  state_t state, state_d;

  logic                  rw_q;
  logic [3:0]            id_q, len_q, beat_q;
  logic [XY_WIDTH-1:0]   src_x_q, src_y_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            bresp_q;
  logic                  perr_d;

  logic [DATA_WIDTH-1:0] payload;
  logic [1:0]            rx_type;
  logic                  w_hs, r_hs, at_last;
  logic [DATA_WIDTH-1:0] wr_head, rd_head;
  logic                  unused_ok;

  assign payload = rx_flit[DATA_WIDTH-1:0];
  assign rx_type = rx_flit[FLIT_WIDTH-1 -: 2];
  assign at_last = (beat_q == len_q);
  assign w_hs    = (state == S_W) && rx_valid && M_WREADY;
  assign r_hs    = (state == S_R) && M_RVALID && tx_ready;

  // Response headers swap roles: we become the source, the requester the destination.
  assign wr_head = {1'b1, id_q, 4'd0,  myx, myy, src_x_q, src_y_q, {PAD{1'b0}}};
  assign rd_head = {1'b0, id_q, len_q, myx, myy, src_x_q, src_y_q, {PAD{1'b0}}};

  assign M_AWID    = id_q;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = len_q;
  assign M_AWSIZE  = 3'b010;
  assign M_AWBURST = 2'b01;
  assign M_WID     = id_q;
  assign M_WDATA   = payload;
  assign M_WSTRB   = 4'hF;
  assign M_WLAST   = at_last;
  assign M_ARID    = id_q;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = len_q;
  assign M_ARSIZE  = 3'b010;
  assign M_ARBURST = 2'b01;
  assign busy      = (state != S_IDLE);
  assign unused_ok = ^{M_BID, M_RID, M_RRESP, payload};

`ifdef SNI_RRESP_TRAILER_EN
  logic [1:0] rresp_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rw_q      <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      addr_q    <= '0;
      bresp_q   <= '0;
      proto_err <= 1'b0;
`ifdef SNI_RRESP_TRAILER_EN
      rresp_q   <= '0;
`endif
    end else begin
      state     <= state_d;
      proto_err <= perr_d;
      if (state == S_IDLE && rx_valid && rx_type == T_HEAD) begin
        rw_q    <= payload[DATA_WIDTH-1];
        id_q    <= payload[DATA_WIDTH-2 -: 4];
        len_q   <= payload[DATA_WIDTH-6 -: 4];
        src_x_q <= payload[DATA_WIDTH-10 -: XY_WIDTH];
        src_y_q <= payload[DATA_WIDTH-10-XY_WIDTH -: XY_WIDTH];
        beat_q  <= '0;
`ifdef SNI_RRESP_TRAILER_EN
        rresp_q <= '0;
`endif
      end
      if (state == S_ADDR && rx_valid)
        addr_q <= payload[ADDR_WIDTH-1:0];
      if (w_hs || r_hs)
        beat_q <= at_last ? 4'd0 : beat_q + 4'd1;
      if (state == S_B && M_BVALID)
        bresp_q <= M_BRESP;
`ifdef SNI_RRESP_TRAILER_EN
      if (r_hs && M_RRESP > rresp_q)
        rresp_q <= M_RRESP;
`endif
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (rx_valid && rx_type == T_HEAD) state_d = S_ADDR;
      S_ADDR: if (rx_valid) state_d = rw_q ? S_AW : S_AR;
      S_AW:   if (M_AWREADY) state_d = S_W;
      S_W:    if (w_hs && at_last) state_d = S_B;
      S_B:    if (M_BVALID) state_d = S_WH;
      S_WH:   if (tx_ready) state_d = S_WT;
      S_WT:   if (tx_ready) state_d = S_IDLE;
      S_AR:   if (M_ARREADY) state_d = S_RH;
      S_RH:   if (tx_ready) state_d = S_R;
`ifdef SNI_RRESP_TRAILER_EN
      S_R:    if (r_hs && M_RLAST) state_d = S_RT;
      S_RT:   if (tx_ready) state_d = S_IDLE;
`else
      S_R:    if (r_hs && M_RLAST) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_flit   = '0;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    perr_d    = 1'b0;
    case (state)
      S_IDLE: begin
        rx_ready = !rst;
        perr_d   = rx_valid && !rst && (rx_type != T_HEAD);
      end
      S_ADDR: rx_ready = 1'b1;
      S_AW:   M_AWVALID = 1'b1;
      S_W: begin
        // The beat counter decides WLAST; a misplaced TAIL is only reported.
        M_WVALID = rx_valid;
        rx_ready = M_WREADY;
        perr_d   = w_hs && (at_last != (rx_type == T_TAIL));
      end
      S_B:    M_BREADY = 1'b1;
      S_WH: begin
        tx_valid = 1'b1;
        tx_flit  = {T_HEAD, wr_head};
      end
      S_WT: begin
        tx_valid = 1'b1;
        tx_flit  = {T_TAIL, {(DATA_WIDTH-2){1'b0}}, bresp_q};
      end
      S_AR:   M_ARVALID = 1'b1;
      S_RH: begin
        tx_valid = 1'b1;
        tx_flit  = {T_HEAD, rd_head};
      end
      S_R: begin
        tx_valid = M_RVALID;
        M_RREADY = tx_ready;
`ifdef SNI_RRESP_TRAILER_EN
        tx_flit  = {T_BODY, M_RDATA};
`else
        tx_flit  = {(M_RLAST ? T_TAIL : T_BODY), M_RDATA};
`endif
        perr_d   = r_hs && (M_RLAST != at_last);
      end
`ifdef SNI_RRESP_TRAILER_EN
      S_RT: begin
        tx_valid = 1'b1;
        tx_flit  = {T_TAIL, {(DATA_WIDTH-2){1'b0}}, rresp_q};
      end
`endif
      default: ;
    endcase
  end

endmodule
